// File: rtl/popcount_accum.sv
// Pipelined popcount accumulator: per-beat ones-count, optional bipolar mapping,
// saturating multi-beat accumulation, valid/ready result register.

module popcount_tree #(
    parameter int N  = 2,
    parameter int CW = $clog2(N + 1)
) (
    input  logic [N-1:0]  bits,
    output logic [CW-1:0] cnt
);
    generate
        if (N == 1) begin : g_leaf
            assign cnt = bits;
        end else begin : g_split
            localparam int NL  = N / 2;
            localparam int NH  = N - NL;
            localparam int CWL = $clog2(NL + 1);
            localparam int CWH = $clog2(NH + 1);
            logic [CWL-1:0] cnt_l;
            logic [CWH-1:0] cnt_h;
            popcount_tree #(.N(NL)) u_lo (.bits(bits[NL-1:0]), .cnt(cnt_l));
            popcount_tree #(.N(NH)) u_hi (.bits(bits[N-1:NL]), .cnt(cnt_h));
            assign cnt = CW'(cnt_l) + CW'(cnt_h);
        end
    endgenerate
endmodule

module popcount_accum #(
    parameter int IN_W      = 14,
    parameter int ACC_W     = 16,
    parameter int MAX_BEATS = 64
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [IN_W-1:0]                in_data,
    input  logic                           in_last,
    input  logic                           in_mode,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [ACC_W-1:0]               out_sum,
    output logic [$clog2(MAX_BEATS+1)-1:0] out_beats,
    output logic                           out_sat,
    output logic                           out_trunc
);
    localparam int CW = $clog2(IN_W + 1);
    localparam int BW = $clog2(MAX_BEATS + 1);
    localparam logic signed [ACC_W:0] IN_W_X  = (ACC_W + 1)'(IN_W);
    localparam logic [ACC_W-1:0]      SAT_MAX = {1'b0, {(ACC_W - 1){1'b1}}};
    localparam logic [ACC_W-1:0]      SAT_MIN = {1'b1, {(ACC_W - 1){1'b0}}};

    logic          en;
    logic [CW-1:0] pop_cnt;

    // stage P
    logic          p_valid;
    logic [CW-1:0] p_cnt;
    logic          p_last;
    logic          p_mode;

    // stage A
    logic [ACC_W-1:0] acc;
    logic [BW-1:0]    beats;
    logic             mode_q;
    logic             sat_q;
    logic             first;

    logic                    mode_eff;
    logic signed [ACC_W:0]   cnt_x;
    logic signed [ACC_W:0]   term;
    logic signed [ACC_W:0]   acc_x;
    logic signed [ACC_W:0]   sum_raw;
    logic                    ovf;
    logic [ACC_W-1:0]        sum_c;
    logic [BW:0]             beats_nx;
    logic                    hit_max;
    logic                    step;
    logic                    close;

    // A held, unconsumed result freezes every stage.
    assign en       = !(out_valid && !out_ready);
    assign in_ready = en;

    popcount_tree #(.N(IN_W)) u_pop (.bits(in_data), .cnt(pop_cnt));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_valid <= 1'b0;
            p_cnt   <= '0;
            p_last  <= 1'b0;
            p_mode  <= 1'b0;
        end else if (en) begin
            p_valid <= in_valid;
            if (in_valid) begin
                p_cnt  <= pop_cnt;
                p_last <= in_last;
                p_mode <= in_mode;
            end
        end
    end

    always_comb begin
        mode_eff = first ? p_mode : mode_q;
        cnt_x    = signed'({{(ACC_W + 1 - CW){1'b0}}, p_cnt});
        term     = mode_eff ? (cnt_x <<< 1) - IN_W_X : cnt_x;
        acc_x    = first ? '0 : signed'({acc[ACC_W-1], acc});
        sum_raw  = acc_x + term;
        // one extra bit is enough: a single term can't jump past the extended range
        ovf      = sum_raw[ACC_W] ^ sum_raw[ACC_W-1];
        sum_c    = ovf ? (sum_raw[ACC_W] ? SAT_MIN : SAT_MAX) : sum_raw[ACC_W-1:0];
        beats_nx = {1'b0, beats} + (BW + 1)'(1);
        hit_max  = (beats_nx == (BW + 1)'(MAX_BEATS));
        step     = en && p_valid;
        close    = step && (p_last || hit_max);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            beats  <= '0;
            mode_q <= 1'b0;
            sat_q  <= 1'b0;
            first  <= 1'b1;
        end else if (step) begin
            if (close) begin
                acc   <= '0;
                beats <= '0;
                sat_q <= 1'b0;
                first <= 1'b1;
            end else begin
                acc    <= sum_c;
                beats  <= beats_nx[BW-1:0];
                sat_q  <= sat_q | ovf;
                mode_q <= mode_eff;
                first  <= 1'b0;
            end
        end
    end

    // en implies any held result is being consumed this cycle, so reload-or-clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_beats <= '0;
            out_sat   <= 1'b0;
            out_trunc <= 1'b0;
        end else if (en) begin
            out_valid <= close;
            if (close) begin
                out_sum   <= sum_c;
                out_beats <= beats_nx[BW-1:0];
                out_sat   <= sat_q | ovf;
                out_trunc <= !p_last;
            end
        end
    end
endmodule

// File: tb/tb_popcount_accum.sv
// Randomized bench for popcount_accum: three parameterisations checked against
// a vector-level reference model, plus directed latency/backpressure/reset checks.

module tb_popcount_accum;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]  iv;
    logic [13:0] din;
    logic        last, mode, ordy;
    logic        r0, r1, r2, v0, v1, v2;
    logic [15:0] s0, s2;
    logic [7:0]  s1;
    logic [6:0]  b0, b1;
    logic [2:0]  b2;
    logic        sa0, sa1, sa2, tr0, tr1, tr2;
    logic [2:0]  rdy;
    assign rdy = {r2, r1, r0};

    popcount_accum u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(r0), .in_data(din),
        .in_last(last), .in_mode(mode), .out_valid(v0), .out_ready(ordy),
        .out_sum(s0), .out_beats(b0), .out_sat(sa0), .out_trunc(tr0));
    popcount_accum #(.ACC_W(8)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(r1), .in_data(din),
        .in_last(last), .in_mode(mode), .out_valid(v1), .out_ready(ordy),
        .out_sum(s1), .out_beats(b1), .out_sat(sa1), .out_trunc(tr1));
    popcount_accum #(.MAX_BEATS(4)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(r2), .in_data(din),
        .in_last(last), .in_mode(mode), .out_valid(v2), .out_ready(ordy),
        .out_sum(s2), .out_beats(b2), .out_sat(sa2), .out_trunc(tr2));

    typedef struct packed {
        logic [1:0]  inst;
        logic [15:0] sum;
        logic [6:0]  beats;
        logic        sat;
        logic        trunc;
    } res_t;

    res_t expq[$];
    res_t obsq[$];
    int   pc_q[$];
    bit   md_q[$];
    int   tests = 0;
    int   fails = 0;
    bit   rnd_bp = 0;

    always @(negedge clk) begin
        if (rst_n && ordy) begin
            if (v0) obsq.push_back(res_t'{2'd0, s0, b0, sa0, tr0});
            if (v1) obsq.push_back(res_t'{2'd1, {{8{s1[7]}}, s1}, b1, sa1, tr1});
            if (v2) obsq.push_back(res_t'{2'd2, s2, {4'b0, b2}, sa2, tr2});
        end
    end

    always @(posedge clk) begin
        if (rnd_bp) begin
            #1 ordy = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation still running at 300us, want finished");
        $fatal(1);
    end

    function automatic int accw(input int idx);
        return (idx == 1) ? 8 : 16;
    endfunction

    function automatic int maxb(input int idx);
        return (idx == 2) ? 4 : 64;
    endfunction

    // Reference: a vector's value is the running clamped sum of its terms,
    // with the bipolar/unsigned choice taken from its first beat.
    task automatic close_vec(input int idx, input bit lst);
        int a = 0;
        bit sat = 0;
        int mx = (1 << (accw(idx) - 1)) - 1;
        int mn = -(mx + 1);
        for (int i = 0; i < pc_q.size(); i++) begin
            a += md_q[0] ? (2 * pc_q[i] - 14) : pc_q[i];
            if (a > mx) begin a = mx; sat = 1; end
            if (a < mn) begin a = mn; sat = 1; end
        end
        expq.push_back(res_t'{2'(idx), 16'(a), 7'(pc_q.size()), sat, !lst});
        pc_q.delete();
        md_q.delete();
    endtask

    task automatic send(input int idx, input logic [13:0] d, input logic l,
                        input logic m, output int cyc);
        bit ok = 0;
        iv = '0;
        iv[idx] = 1'b1;
        din = d; last = l; mode = m;
        cyc = 0;
        while (!ok && cyc < 200) begin
            @(negedge clk);
            ok = rdy[idx];
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!ok) begin
            tests++; fails++;
            $display("FAIL send_timeout inst %0d: in_ready got 0 for 200 cycles, want 1", idx);
        end else begin
            pc_q.push_back($countones(d));
            md_q.push_back(m);
            if (l || pc_q.size() == maxb(idx)) close_vec(idx, l);
        end
    endtask

    task automatic send_vec(input int idx, input int n, input bit gaps, output int cyc_tot);
        int c;
        cyc_tot = 0;
        for (int i = 0; i < n; i++) begin
            send(idx, 14'($urandom), (i == n - 1), 1'($urandom_range(0, 1)), c);
            cyc_tot += c;
            if (gaps) begin
                iv = '0;
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic drain();
        iv = '0;
        rnd_bp = 0;
        @(posedge clk);
        #2 ordy = 1'b1;
        repeat (12) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1;
        tests++;
        if ({v0, s0, b0, sa0, tr0} !== '0) begin
            fails++;
            $display("FAIL reset_outputs got v=%b sum=%h beats=%0d sat=%b trunc=%b want all 0",
                     v0, s0, b0, sa0, tr0);
        end
        tests++;
        if (r0 !== 1'b1) begin
            fails++; $display("FAIL reset_in_ready got %b want 1", r0);
        end
        #22 rst_n = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (v0 !== 1'b0 || r0 !== 1'b1) begin
            fails++; $display("FAIL idle_after_reset got v=%b rdy=%b want v=0 rdy=1", v0, r0);
        end
    endtask

    task automatic test_single();
        int c;
        send(0, 14'h3FFF, 1'b1, 1'b0, c);
        iv = '0;
        tests++;
        if (v0 !== 1'b0) begin
            fails++; $display("FAIL single_early_valid got %b want 0", v0);
        end
        @(posedge clk); #1;
        tests++;
        if (v0 !== 1'b1 || s0 !== 16'd14 || b0 !== 7'd1) begin
            fails++;
            $display("FAIL single_latency got v=%b sum=%0d beats=%0d want v=1 sum=14 beats=1",
                     v0, s0, b0);
        end
        send(0, 14'h3FFF, 1'b1, 1'b1, c);
        drain();
        tests++;
        if (obsq.size() !== expq.size()) begin
            fails++; $display("FAIL single_count got %0d want %0d", obsq.size(), expq.size());
        end
        for (int i = 0; i < expq.size() && i < obsq.size(); i++) begin
            tests++;
            if (obsq[i] !== expq[i]) begin
                fails++; $display("FAIL single_res[%0d] got %h want %h", i, obsq[i], expq[i]);
            end
        end
        obsq.delete(); expq.delete();
    endtask

    task automatic test_bipolar();
        int c;
        send(0, 14'h0001, 1'b0, 1'b1, c);
        send(0, 14'h0000, 1'b0, 1'b0, c);
        send(0, 14'h2AAA, 1'b1, 1'b0, c);
        for (int v = 0; v < 6; v++) send_vec(0, $urandom_range(1, 5), 1'b0, c);
        drain();
        tests++;
        if (obsq.size() !== expq.size()) begin
            fails++; $display("FAIL bipolar_count got %0d want %0d", obsq.size(), expq.size());
        end
        for (int i = 0; i < expq.size() && i < obsq.size(); i++) begin
            tests++;
            if (obsq[i] !== expq[i]) begin
                fails++; $display("FAIL bipolar_res[%0d] got %h want %h", i, obsq[i], expq[i]);
            end
        end
        obsq.delete(); expq.delete();
    endtask

    task automatic test_saturation();
        int c;
        for (int i = 0; i < 10; i++) send(1, 14'h3FFF, (i == 9), 1'b0, c);
        send(1, 14'h000F, 1'b1, 1'b0, c);
        for (int i = 0; i < 10; i++) send(1, 14'h0000, (i == 9), 1'b1, c);
        for (int i = 0; i < 12; i++) send(1, 14'h3FFF, 1'b0, 1'b1, c);
        for (int i = 0; i < 3; i++) send(1, 14'h0000, (i == 2), 1'b0, c);
        for (int v = 0; v < 4; v++) send_vec(1, $urandom_range(8, 14), 1'b0, c);
        drain();
        tests++;
        if (obsq.size() !== expq.size()) begin
            fails++; $display("FAIL sat_count got %0d want %0d", obsq.size(), expq.size());
        end
        for (int i = 0; i < expq.size() && i < obsq.size(); i++) begin
            tests++;
            if (obsq[i] !== expq[i]) begin
                fails++; $display("FAIL sat_res[%0d] got %h want %h", i, obsq[i], expq[i]);
            end
        end
        obsq.delete(); expq.delete();
    endtask

    task automatic test_trunc();
        int c;
        for (int i = 0; i < 6; i++) send(2, 14'h0003, (i == 5), 1'b0, c);
        for (int v = 0; v < 4; v++) send_vec(2, $urandom_range(1, 10), 1'b1, c);
        drain();
        tests++;
        if (obsq.size() !== expq.size()) begin
            fails++; $display("FAIL trunc_count got %0d want %0d", obsq.size(), expq.size());
        end
        for (int i = 0; i < expq.size() && i < obsq.size(); i++) begin
            tests++;
            if (obsq[i] !== expq[i]) begin
                fails++; $display("FAIL trunc_res[%0d] got %h want %h", i, obsq[i], expq[i]);
            end
        end
        obsq.delete(); expq.delete();
    endtask

    task automatic test_backpressure();
        int c;
        ordy = 1'b0;
        send(0, 14'h3FFF, 1'b1, 1'b0, c);
        send(0, 14'h00FF, 1'b0, 1'b1, c);
        din = 14'h0F0F; last = 1'b1; mode = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++;
            if (r0 !== 1'b0 || v0 !== 1'b1 || s0 !== 16'd14 || b0 !== 7'd1) begin
                fails++;
                $display("FAIL stall_cycle%0d got rdy=%b v=%b sum=%0d beats=%0d want rdy=0 v=1 sum=14 beats=1",
                         i, r0, v0, s0, b0);
            end
            @(posedge clk); #1;
        end
        ordy = 1'b1;
        send(0, 14'h0F0F, 1'b1, 1'b0, c);
        for (int v = 0; v < 3; v++) send_vec(0, $urandom_range(1, 3), 1'b0, c);
        drain();
        tests++;
        if (obsq.size() !== expq.size()) begin
            fails++; $display("FAIL bp_count got %0d want %0d", obsq.size(), expq.size());
        end
        for (int i = 0; i < expq.size() && i < obsq.size(); i++) begin
            tests++;
            if (obsq[i] !== expq[i]) begin
                fails++; $display("FAIL bp_res[%0d] got %h want %h", i, obsq[i], expq[i]);
            end
        end
        obsq.delete(); expq.delete();
    endtask

    task automatic test_back_to_back();
        int c, tot = 0, n = 0, len;
        for (int v = 0; v < 10; v++) begin
            len = (v < 6) ? 1 : $urandom_range(2, 4);
            send_vec(0, len, 1'b0, c);
            tot += c;
            n += len;
        end
        tests++;
        if (tot !== n) begin
            fails++; $display("FAIL b2b_cycles got %0d want %0d", tot, n);
        end
        drain();
        tests++;
        if (obsq.size() !== expq.size()) begin
            fails++; $display("FAIL b2b_count got %0d want %0d", obsq.size(), expq.size());
        end
        for (int i = 0; i < expq.size() && i < obsq.size(); i++) begin
            tests++;
            if (obsq[i] !== expq[i]) begin
                fails++; $display("FAIL b2b_res[%0d] got %h want %h", i, obsq[i], expq[i]);
            end
        end
        obsq.delete(); expq.delete();
    endtask

    task automatic test_random();
        int c;
        rnd_bp = 1;
        for (int v = 0; v < 20; v++) send_vec(0, $urandom_range(1, 6), 1'b1, c);
        drain();
        tests++;
        if (obsq.size() !== expq.size()) begin
            fails++; $display("FAIL rand_count got %0d want %0d", obsq.size(), expq.size());
        end
        for (int i = 0; i < expq.size() && i < obsq.size(); i++) begin
            tests++;
            if (obsq[i] !== expq[i]) begin
                fails++; $display("FAIL rand_res[%0d] got %h want %h", i, obsq[i], expq[i]);
            end
        end
        obsq.delete(); expq.delete();
    endtask

    task automatic test_reset_mid();
        int c;
        ordy = 1'b0;
        send(0, 14'h3FFF, 1'b1, 1'b0, c);
        send(0, 14'h0FFF, 1'b0, 1'b0, c);
        iv = '0;
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({v0, s0, b0, sa0, tr0} !== '0 || r0 !== 1'b1) begin
            fails++;
            $display("FAIL mid_reset got v=%b sum=%h beats=%0d rdy=%b want v=0 sum=0 beats=0 rdy=1",
                     v0, s0, b0, r0);
        end
        pc_q.delete(); md_q.delete(); expq.delete(); obsq.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        ordy = 1'b1;
        send(0, 14'h0007, 1'b1, 1'b0, c);
        drain();
        tests++;
        if (obsq.size() !== expq.size()) begin
            fails++; $display("FAIL mid_reset_count got %0d want %0d", obsq.size(), expq.size());
        end
        for (int i = 0; i < expq.size() && i < obsq.size(); i++) begin
            tests++;
            if (obsq[i] !== expq[i]) begin
                fails++; $display("FAIL mid_reset_res[%0d] got %h want %h", i, obsq[i], expq[i]);
            end
        end
        obsq.delete(); expq.delete();
    endtask

    initial begin
        iv = '0; din = '0; last = 1'b0; mode = 1'b0; ordy = 1'b1;
        test_reset();
        test_single();
        test_bipolar();
        test_saturation();
        test_trunc();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
